substitution_layer_folded: RTL

Time-multiplexed, parametrised Ascon substitution layer (pS). It applies the 5-bit Ascon S-box to all 64 bit-columns of the 320-bit state, processing SBOX_PER_CYCLE columns per clock, so area can be traded against latency. It sits inside the permutation datapath between the constant-addition and linear-diffusion stages. A start/busy/done handshake lets the permutation FSM sequence it.

---
 rtl/substitution_layer_folded_if.sv | 34 +++
 rtl/substitution_layer_folded.sv | 134 +++++++++++++
 2 files changed

// File: rtl/substitution_layer_folded_if.sv
// Handshake and state bus of the folded Ascon substitution layer.
// Carries inverse_i when SUBSTITUTION_INVERSE_EN is defined.
interface substitution_if;
  logic              start_i;
  logic [4:0][63:0]  substitution_target_i;
  logic [4:0][63:0]  substitution_substitute_o;
  logic              busy_o;
  logic              done_o;
`ifdef SUBSTITUTION_INVERSE_EN
  logic              inverse_i;
`endif

  modport master (
`ifdef SUBSTITUTION_INVERSE_EN
    output inverse_i,
`endif
    output start_i,
    output substitution_target_i,
    input  substitution_substitute_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
`ifdef SUBSTITUTION_INVERSE_EN
    input  inverse_i,
`endif
    input  start_i,
    input  substitution_target_i,
    output substitution_substitute_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/substitution_layer_folded.sv
// Folded Ascon pS layer: SBOX_PER_CYCLE columns substituted per clock, 64/SBOX_PER_CYCLE clocks per state.
// Optional macro SUBSTITUTION_INVERSE_EN adds inverse_i selecting the inverse S-box.
module substitution_layer_folded #(
  parameter int SBOX_PER_CYCLE = 16
) (
  input  logic clock_i,
  input  logic resetb_i,
  substitution_if.slave bus
);

  localparam int N_CHUNKS = 64 / SBOX_PER_CYCLE;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  typedef logic [4:0][63:0] type_state;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  if (!(SBOX_PER_CYCLE == 1  || SBOX_PER_CYCLE == 2  || SBOX_PER_CYCLE == 4 ||
        SBOX_PER_CYCLE == 8  || SBOX_PER_CYCLE == 16 || SBOX_PER_CYCLE == 32 ||
        SBOX_PER_CYCLE == 64)) begin : g_bad_param
    $error("SBOX_PER_CYCLE must be one of 1, 2, 4, 8, 16, 32, 64");
  end

  localparam logic [4:0] SBOX_TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
    return SBOX_TBL[x];
  endfunction

  // The inverse is derived from the forward table so the two can never disagree.
  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    logic [4:0] y;
    y = '0;
    for (int j = 0; j < 32; j++)
      if (SBOX_TBL[j] == x) y = 5'(j);
    return y;
  endfunction

  function automatic type_state apply_chunk(input type_state s, input int k, input logic inv);
    type_state  r;
    logic [4:0] x;
    logic [4:0] y;
    int         col;
    r = s;
    for (int c = 0; c < SBOX_PER_CYCLE; c++) begin
      col = k * SBOX_PER_CYCLE + c;
      x   = {s[0][col], s[1][col], s[2][col], s[3][col], s[4][col]};
      y   = inv ? sbox_inv(x) : sbox_fwd(x);
      r[0][col] = y[4];
      r[1][col] = y[3];
      r[2][col] = y[2];
      r[3][col] = y[1];
      r[4][col] = y[0];
    end
    return r;
  endfunction

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  type_state        state_q;
  logic             busy_q;
  logic             done_q;
  logic             inv_q;
  logic             inv_start;

  always_comb begin
`ifdef SUBSTITUTION_INVERSE_EN
    inv_start = bus.inverse_i;
`else
    inv_start = 1'b0;
`endif
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm     <= IDLE;
      cnt     <= '0;
      state_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (bus.start_i) begin
            state_q <= apply_chunk(bus.substitution_target_i, 0, inv_start);
            inv_q   <= inv_start;
            if (N_CHUNKS == 1) begin
              fsm    <= DONE;
              cnt    <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              fsm    <= RUN;
              cnt    <= CNT_W'(1);
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end else begin
            fsm    <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          state_q <= apply_chunk(state_q, int'(cnt), inv_q);
          if (cnt == CNT_W'(N_CHUNKS - 1)) begin
            fsm    <= DONE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          fsm    <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.substitution_substitute_o = state_q;
  assign bus.busy_o                    = busy_q;
  assign bus.done_o                    = done_q;

endmodule
